// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract: one full-adder cell processes one bit per cycle, LSB first.
// Subtraction is a + ~b + 1. The inverted b and the carry-in of 1 are loaded at start.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  // state  | meaning
  // S_IDLE | waiting for start; results hold
  // S_RUN  | one bit of the sum per cycle, WIDTH cycles
  // S_DONE | one-cycle completion pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             bit_s, bit_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    bit_s = opa_q[0] ^ opb_q[0] ^ carry_q;
    bit_c = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          // Cancelled mid-operation: partial results are left as-is and not valid.
          state_d = S_IDLE;
        end else begin
          sum_d   = {bit_s, sum_q[WIDTH-1:1]};
          opa_d   = {1'b0, opa_q[WIDTH-1:1]};
          opb_d   = {1'b0, opb_q[WIDTH-1:1]};
          carry_d = bit_c;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            cout_d  = bit_c;
            ovf_d   = carry_q ^ bit_c;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule
